// File: rtl/playback_ctrl_if.sv
// rtl/playback_ctrl_if.sv - control, FIFO status and DAC/flow-control signals of playback_ctrl
interface playback_ctrl_if #(
    parameter int FILL_BITS = 12,
    parameter int CNT_BITS  = 8
) ();
    logic                 enable;
    logic                 clr_underrun;
    logic [FILL_BITS-1:0] fifo_fill;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_rd_en;
    logic                 dac_reset;
    logic                 send_ok;
    logic [1:0]           state;
    logic                 underrun;
    logic [CNT_BITS-1:0]  underrun_count;

    modport master (
        output enable, clr_underrun, fifo_fill, fifo_empty, fifo_full,
        input  fifo_rd_en, dac_reset, send_ok, state, underrun, underrun_count
    );

    modport slave (
        input  enable, clr_underrun, fifo_fill, fifo_empty, fifo_full,
        output fifo_rd_en, dac_reset, send_ok, state, underrun, underrun_count
    );
endinterface

// File: rtl/playback_ctrl.sv
// rtl/playback_ctrl.sv - PCM playback sequencer: sample-rate FIFO pops, DAC mute, UART flow control
module playback_ctrl #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int SAMPLE_FREQ = 44_100,
    parameter int FILL_BITS   = 12,
    parameter int START_LEVEL = 2048,
    parameter int LOW_WATER   = 1228,
    parameter int HIGH_WATER  = 2048,
    parameter int CNT_BITS    = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    playback_ctrl_if.slave bus
);
    localparam int DIV      = CLK_FREQ / SAMPLE_FREQ;
    localparam int DIV_BITS = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_BITS-1:0]  DIV_LAST = DIV_BITS'(DIV - 1);
    localparam logic [FILL_BITS-1:0] START_L  = FILL_BITS'(START_LEVEL);
    localparam logic [FILL_BITS-1:0] LOW_L    = FILL_BITS'(LOW_WATER);
    localparam logic [FILL_BITS-1:0] HIGH_L   = FILL_BITS'(HIGH_WATER);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFILL  = 2'd1,
        PLAY     = 2'd2,
        UNDERRUN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_BITS-1:0]   div_q, div_d;
    logic                  rd_en_q, rd_en_d;
    logic                  dac_reset_q;
    logic                  send_ok_q, send_ok_d;
    logic                  underrun_q, underrun_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  tick;
    logic                  urun_evt;

    // Divider free-runs in every state so ticks stay on a fixed sample grid.
    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rd_en_d  = 1'b0;
        urun_evt = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = PREFILL;
                PREFILL:  if (bus.fifo_fill >= START_L || bus.fifo_full) state_d = PLAY;
                PLAY: begin
                    if (tick) begin
                        if (bus.fifo_empty) begin
                            state_d  = UNDERRUN;
                            urun_evt = 1'b1;
                        end else begin
                            rd_en_d = 1'b1;
                        end
                    end
                end
                UNDERRUN: if (tick) state_d = PREFILL;
                default:  state_d = IDLE;
            endcase
        end
    end

    // A same-cycle underrun beats the clear, restarting the count at one.
    always_comb begin
        underrun_d = underrun_q;
        count_d    = count_q;
        if (urun_evt) begin
            underrun_d = 1'b1;
            if (bus.clr_underrun)  count_d = CNT_BITS'(1);
            else if (count_q != '1) count_d = count_q + 1'b1;
        end else if (bus.clr_underrun) begin
            underrun_d = 1'b0;
            count_d    = '0;
        end
    end

    always_comb begin
        send_ok_d = send_ok_q;
        if (bus.fifo_fill >= HIGH_L || bus.fifo_full)       send_ok_d = 1'b0;
        else if (bus.fifo_fill <= LOW_L && !bus.fifo_full)  send_ok_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            rd_en_q     <= 1'b0;
            dac_reset_q <= 1'b1;
            send_ok_q   <= 1'b1;
            underrun_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rd_en_q     <= rd_en_d;
            dac_reset_q <= (state_q != PLAY);
            send_ok_q   <= send_ok_d;
            underrun_q  <= underrun_d;
            count_q     <= count_d;
        end
    end

    assign bus.fifo_rd_en     = rd_en_q;
    assign bus.dac_reset      = dac_reset_q;
    assign bus.send_ok        = send_ok_q;
    assign bus.state          = state_q;
    assign bus.underrun       = underrun_q;
    assign bus.underrun_count = count_q;
endmodule

// File: tb/tb_playback_ctrl.sv
// tb/tb_playback_ctrl.sv - scoreboard bench for playback_ctrl at DIV = 10
module tb_playback_ctrl;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   ecnt;
    int   exp_q[$];

    playback_ctrl_if #(.FILL_BITS(12), .CNT_BITS(8)) bus ();

    playback_ctrl #(
        .CLK_FREQ(1000), .SAMPLE_FREQ(100), .FILL_BITS(12),
        .START_LEVEL(8), .LOW_WATER(4), .HIGH_WATER(8), .CNT_BITS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; tick edges are the multiples of 10.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ecnt <= 0;
        else          ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        int g;
        g = 0;
        while (ecnt < n && g < 20000) begin
            step();
            g++;
        end
        chk("run_to", ecnt, n);
    endtask

    task automatic align(input int k);
        int g;
        g = 0;
        while ((ecnt % 10) != k && g < 20) begin
            step();
            g++;
        end
        chk("align", ecnt % 10, k);
    endtask

    // Each observed pop is matched against the next expected pop edge.
    always @(negedge clk) begin
        if (bus.fifo_rd_en) begin
            if (exp_q.size() == 0) chk("rd_unexpected", ecnt, -1);
            else                   chk("rd_cycle", ecnt, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        bus.enable = 1'b0;
        bus.clr_underrun = 1'b0;
        bus.fifo_fill = '0;
        bus.fifo_empty = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) step();
        chk("rst_state", bus.state, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_dac", bus.dac_reset, 1);
        chk("rst_send_ok", bus.send_ok, 1);
        chk("rst_urun", bus.underrun, 0);
        chk("rst_count", bus.underrun_count, 0);

        // Fill ramps 0..9; level 8 is sampled at edge 9 so PLAY starts there.
        bus.enable = 1'b1;
        exp_q.push_back(10);
        exp_q.push_back(20);
        exp_q.push_back(30);
        exp_q.push_back(40);
        reset_n = 1'b1;
        for (int f = 1; f <= 9; f++) begin
            step();
            bus.fifo_fill = 12'(f);
            if (ecnt == 8) begin
                chk("prefill_state", bus.state, 1);
                chk("prefill_dac", bus.dac_reset, 1);
            end
        end
        chk("play_state", bus.state, 2);
        chk("play_dac_lag", bus.dac_reset, 1);
        step();
        chk("play_dac", bus.dac_reset, 0);

        // Empty FIFO at the edge-50 tick.
        run_to(45);
        bus.fifo_empty = 1'b1;
        run_to(50);
        chk("urun_state", bus.state, 3);
        chk("urun_flag", bus.underrun, 1);
        chk("urun_count", bus.underrun_count, 1);
        step();
        chk("urun_dac", bus.dac_reset, 1);
        run_to(55);
        bus.fifo_empty = 1'b0;
        run_to(59);
        chk("urun_wait", bus.state, 3);
        step();
        chk("urun_prefill", bus.state, 1);
        step();
        chk("urun_replay", bus.state, 2);
        exp_q.push_back(70);

        // Enable drops in the tick cycle before edge 80.
        run_to(79);
        bus.enable = 1'b0;
        step();
        chk("drop_state", bus.state, 0);
        chk("drop_rd_en", bus.fifo_rd_en, 0);
        bus.enable = 1'b1;
        exp_q.push_back(90);
        exp_q.push_back(100);
        run_to(82);
        chk("reenable_state", bus.state, 2);

        // Asynchronous reset while a pop strobe is high.
        run_to(110);
        chk("pre_rst_rd_en", bus.fifo_rd_en, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_rd_en", bus.fifo_rd_en, 0);
        chk("arst_dac", bus.dac_reset, 1);
        chk("arst_send_ok", bus.send_ok, 1);
        chk("arst_urun", bus.underrun, 0);
        chk("arst_count", bus.underrun_count, 0);
        exp_q.push_back(10);
        reset_n = 1'b1;
        run_to(12);

        // Hysteresis sweep with playback idle.
        bus.enable = 1'b0;
        step();
        bus.fifo_fill = 12'd0;  step(); chk("sok_fill0", bus.send_ok, 1);
        bus.fifo_fill = 12'd8;  step(); chk("sok_fill8", bus.send_ok, 0);
        bus.fifo_fill = 12'd5;  step(); chk("sok_fill5", bus.send_ok, 0);
        bus.fifo_fill = 12'd4;  step(); chk("sok_fill4", bus.send_ok, 1);
        bus.fifo_fill = 12'd3;
        bus.fifo_full = 1'b1;   step(); chk("sok_full", bus.send_ok, 0);
        bus.fifo_full = 1'b0;   step(); chk("sok_unfull", bus.send_ok, 1);

        // One underrun per 20 cycles: about 300 events saturate the count.
        bus.fifo_fill = 12'd9;
        bus.fifo_empty = 1'b1;
        bus.enable = 1'b1;
        repeat (6100) step();
        chk("sat_count", bus.underrun_count, 255);
        chk("sat_flag", bus.underrun, 1);

        align(5);
        bus.enable = 1'b0;
        bus.clr_underrun = 1'b1;
        step();
        bus.clr_underrun = 1'b0;
        bus.enable = 1'b1;
        chk("clr_count", bus.underrun_count, 0);
        chk("clr_flag", bus.underrun, 0);
        step();
        chk("clr_prefill", bus.state, 1);
        step();
        chk("clr_play", bus.state, 2);
        step();
        bus.clr_underrun = 1'b1;
        step();
        bus.clr_underrun = 1'b0;
        chk("clr_evt_state", bus.state, 3);
        chk("clr_evt_flag", bus.underrun, 1);
        chk("clr_evt_count", bus.underrun_count, 1);

        bus.enable = 1'b0;
        repeat (3) step();
        chk("q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
